// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: line states, receiver FSM states and default
// timing constants shared by the low speed receiver and its bench.
package usb_rx_pkg;

    // {D+,D-}: low speed idle (J) has D- high
    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } d_port_t;

    typedef enum logic [2:0] {
        RESET,
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_EOP
    } rx_state_t;

    localparam int CLK_DIV_DEF     = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int STUFF_LIMIT_DEF = 6;

endpackage

// File: rtl/usb_rx_if.sv
// usb_rx_if: byte/status bundle from the receiver to the SIE.
// master drives it (usb_rx), slave observes it (SIE).
interface usb_rx_if;

    logic [7:0] data;
    logic       valid;
    logic       active;
    logic       eop;
    logic       error;

    modport master (output data, valid, active, eop, error);
    modport slave  (input  data, valid, active, eop, error);

endinterface

// File: rtl/usb_rx_dpll.sv
// usb_rx_dpll: synchronizes D+/D-, realigns the bit phase on
// every line change and strobes the line state at mid-bit.
module usb_rx_dpll
    import usb_rx_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic    clk,
    input  logic    reset_n,
    input  d_port_t d_i,
    output d_port_t line,
    output logic    stb
);

    localparam int CW = $clog2(CLK_DIV);

    d_port_t       sync_q [SYNC_STAGES];
    logic [CW-1:0] phase_q;
    logic          chg;

    assign line = sync_q[SYNC_STAGES-1];
    assign chg  = sync_q[SYNC_STAGES-1] != sync_q[SYNC_STAGES-2];
    assign stb  = phase_q == CW'(CLK_DIV/2 - 1);

    // Input synchronizer chain, idles at J
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= J;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Free-running bit phase, zeroed when the line changes
    always_ff @(posedge clk) begin
        if (!reset_n || chg)
            phase_q <= '0;
        else if (phase_q == CW'(CLK_DIV - 1))
            phase_q <= '0;
        else
            phase_q <= phase_q + 1'b1;
    end

endmodule

// File: rtl/usb_rx.sv
// usb_rx: low speed USB receiver; SYNC/EOP detection, NRZI
// decode, bit destuffing and LSB-first byte assembly.
module usb_rx
    import usb_rx_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    input  d_port_t  d_i,
    input  logic     tx_en,
    usb_rx_if.master sie
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);

    d_port_t   line, prev_q;
    logic      stb, bit_v;
    rx_state_t state_q, state_n;
    logic [2:0]    zcnt_q, zcnt_n, bcnt_q, bcnt_n;
    logic [OW-1:0] ones_q, ones_n;
    logic [7:0]    shift_q, shift_n, data_q, data_n;
    logic valid_q, valid_n, active_q, active_n;
    logic eop_q, eop_n, error_q, error_n;
    logic aligned_q, aligned_n;

    usb_rx_dpll #(
        .CLK_DIV     (CLK_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dpll (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (d_i),
        .line    (line),
        .stb     (stb)
    );

    // NRZI: no transition between samples decodes as 1
    assign bit_v = line == prev_q;

    // Previous mid-bit sample for NRZI and SYNC start detection
    always_ff @(posedge clk) begin
        if (!reset_n)  prev_q <= J;
        else if (stb)  prev_q <= line;
    end

    // Next-state, destuff, shift and output pulse logic
    always_comb begin
        state_n   = state_q;
        zcnt_n    = zcnt_q;
        bcnt_n    = bcnt_q;
        ones_n    = ones_q;
        shift_n   = shift_q;
        data_n    = data_q;
        aligned_n = aligned_q;
        active_n  = active_q;
        valid_n   = 1'b0;
        eop_n     = 1'b0;
        error_n   = 1'b0;
        unique case (state_q)
            RESET: state_n = RX_IDLE;
            RX_IDLE: begin
                if (stb && prev_q == J && line == K) begin
                    state_n = RX_SYNC;
                    zcnt_n  = '0;
                end
            end
            RX_SYNC: begin
                if (stb) begin
                    if (line == SE0 || line == SE1) begin
                        error_n = 1'b1;
                        state_n = RX_IDLE;
                    end else if (!bit_v) begin
                        if (zcnt_q != 3'd7) zcnt_n = zcnt_q + 3'd1;
                    end else if (zcnt_q >= 3'd3) begin
                        state_n  = RX_DATA;
                        active_n = 1'b1;
                        bcnt_n   = '0;
                        ones_n   = '0;
                    end else begin
                        error_n = 1'b1;
                        state_n = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (stb) begin
                    if (line == SE0) begin
                        state_n   = RX_EOP;
                        aligned_n = bcnt_q == 3'd0;
                    end else if (line == SE1) begin
                        error_n  = 1'b1;
                        active_n = 1'b0;
                        state_n  = RX_IDLE;
                    end else if (ones_q == OW'(STUFF_LIMIT)) begin
                        ones_n = '0;
                        if (bit_v) begin
                            error_n  = 1'b1;
                            active_n = 1'b0;
                            state_n  = RX_IDLE;
                        end
                    end else begin
                        shift_n = {bit_v, shift_q[7:1]};
                        ones_n  = bit_v ? ones_q + 1'b1 : '0;
                        bcnt_n  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            data_n  = shift_n;
                            valid_n = 1'b1;
                        end
                    end
                end
            end
            RX_EOP: begin
                if (stb) begin
                    unique case (line)
                        SE0: ;
                        J: begin
                            eop_n    = aligned_q;
                            error_n  = !aligned_q;
                            active_n = 1'b0;
                            state_n  = RX_IDLE;
                        end
                        default: begin
                            error_n  = 1'b1;
                            active_n = 1'b0;
                            state_n  = RX_IDLE;
                        end
                    endcase
                end
            end
            default: state_n = RX_IDLE;
        endcase
        if (tx_en && state_q != RESET) begin
            state_n  = RX_IDLE;
            active_n = 1'b0;
            valid_n  = 1'b0;
            eop_n    = 1'b0;
            error_n  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= RESET;
            zcnt_q    <= '0;
            bcnt_q    <= '0;
            ones_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            aligned_q <= 1'b0;
            active_q  <= 1'b0;
            valid_q   <= 1'b0;
            eop_q     <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            zcnt_q    <= zcnt_n;
            bcnt_q    <= bcnt_n;
            ones_q    <= ones_n;
            shift_q   <= shift_n;
            data_q    <= data_n;
            aligned_q <= aligned_n;
            active_q  <= active_n;
            valid_q   <= valid_n;
            eop_q     <= eop_n;
            error_q   <= error_n;
        end
    end

    assign sie.data   = data_q;
    assign sie.valid  = valid_q;
    assign sie.active = active_q;
    assign sie.eop    = eop_q;
    assign sie.error  = error_q;

endmodule
